bus_master_if: RTL and testbench

- Initiator end of the shared 32-bit system bus. Takes single-word read/write commands from a CPU-side port and drives address/request/r_w/data onto the bus.
- Waits for the one-cycle ready pulse from the selected slave, captures read data, and reports completion or timeout back to the CPU side.
- Sits between the CPU memory stage and the bus on which the slave devices hang.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_timeout_counter.sv | 30 +++
 rtl/bus_master_if.sv | 178 +++++++++++++++++
 tb/tb_bus_master_if.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus initiator: FSM state encoding,
// bus direction constants and bus widths.
package bus_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   localparam logic BUS_WRITE = 1'b1;
   localparam logic BUS_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } bus_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting for a slave. expire flags the last allowed
// waiting cycle so the master can abort on that same edge.
module bus_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   logic [7:0] r_count;

   // Restart from zero outside a wait, otherwise advance once per waiting cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign expire = enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/bus_master_if.sv
// Initiator end of the shared 32-bit system bus. Accepts one read/write
// command from the CPU side, runs it on the bus, waits for the slave's
// one-cycle ready pulse (or times out) and reports completion.
// Every bus-facing output is taken straight from a register.
module bus_master_if
   import bus_pkg::*;
#(
   parameter int                TIMEOUT   = 15,
   parameter logic [BUS_AW-1:0] IDLE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [BUS_AW-1:0] cpu_addr,
   input  logic [BUS_DW-1:0] cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic [BUS_DW-1:0] cpu_rdata,
   output logic [BUS_AW-1:0] address,
   inout  wire  [BUS_DW-1:0] data,
   output logic              request,
   output logic              r_w,
   input  logic              ready
);

   bus_state_t r_state;
   bus_state_t w_nextState;

   logic              r_request;
   logic              r_rw;
   logic [BUS_AW-1:0] r_address;
   logic [BUS_DW-1:0] r_wdata;
   logic              r_cpuDone;
   logic              r_cpuErr;
   logic [BUS_DW-1:0] r_cpuRdata;

   logic              w_request;
   logic              w_rw;
   logic [BUS_AW-1:0] w_address;
   logic [BUS_DW-1:0] w_wdata;
   logic              w_cpuDone;
   logic              w_cpuErr;
   logic [BUS_DW-1:0] w_cpuRdata;

   logic              w_readyHit;
   logic              w_timeoutClear;
   logic              w_timeoutEnable;
   logic              w_timeoutExpire;

   // The ready line is pulled low; a floating or unknown level must not
   // complete a transfer, so only a definite 1 is accepted.
   assign w_readyHit = (ready === 1'b1);

   // Only cycles in BUS without ready count toward the abort limit.
   assign w_timeoutClear  = (r_state != BUS);
   assign w_timeoutEnable = (r_state == BUS) && !w_readyHit;

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_timeoutClear),
      .enable (w_timeoutEnable),
      .expire (w_timeoutExpire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: DONE always lasts one cycle and ignores cpu_req.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               w_nextState = BUS;
            end
         end
         BUS: begin
            if (w_readyHit || w_timeoutExpire) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered bus and CPU outputs.
   // Request drops on the very edge that samples ready so a fast slave
   // never sees a second request for the same transfer.
   always_comb begin
      w_request  = r_request;
      w_rw       = r_rw;
      w_address  = r_address;
      w_wdata    = r_wdata;
      w_cpuDone  = 1'b0;
      w_cpuErr   = r_cpuErr;
      w_cpuRdata = r_cpuRdata;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               w_request = 1'b1;
               w_rw      = cpu_we;
               w_address = cpu_addr;
               w_wdata   = cpu_wdata;
            end
         end
         BUS: begin
            if (w_readyHit) begin
               if (r_rw == BUS_READ) begin
                  w_cpuRdata = data;
               end
               w_request = 1'b0;
               w_rw      = BUS_READ;
               w_address = IDLE_ADDR;
               w_cpuDone = 1'b1;
               w_cpuErr  = 1'b0;
            end else if (w_timeoutExpire) begin
               w_request = 1'b0;
               w_rw      = BUS_READ;
               w_address = IDLE_ADDR;
               w_cpuDone = 1'b1;
               w_cpuErr  = 1'b1;
            end
         end
         default: begin
            w_cpuDone = 1'b0;
         end
      endcase
   end

   // Output registers; reset aborts any transfer without a completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_request  <= 1'b0;
         r_rw       <= BUS_READ;
         r_address  <= IDLE_ADDR;
         r_wdata    <= '0;
         r_cpuDone  <= 1'b0;
         r_cpuErr   <= 1'b0;
         r_cpuRdata <= '0;
      end else begin
         r_request  <= w_request;
         r_rw       <= w_rw;
         r_address  <= w_address;
         r_wdata    <= w_wdata;
         r_cpuDone  <= w_cpuDone;
         r_cpuErr   <= w_cpuErr;
         r_cpuRdata <= w_cpuRdata;
      end
   end

   assign request   = r_request;
   assign r_w       = r_rw;
   assign address   = r_address;
   assign cpu_done  = r_cpuDone;
   assign cpu_err   = r_cpuErr;
   assign cpu_rdata = r_cpuRdata;
   assign cpu_busy  = (r_state == BUS) || (r_state == DONE);

   // The master owns the data lines only while a write is on the bus.
   assign data = (r_request && (r_rw == BUS_WRITE)) ? r_wdata : {BUS_DW{1'bz}};

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: a memory slave with programmable wait
// states, a reference model of the expected CPU-side results and a
// monitor that checks every completion against the queued expectation.
module tb_bus_master_if;

   localparam int TIMEOUT_TB = 15;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expRdata;
      int          expReq;
   } sbItem_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;
   logic [31:0] address;
   wire  [31:0] data;
   logic        request;
   logic        r_w;
   logic        ready;

   logic        slvReady = 1'b0;
   logic [31:0] slvRdata = '0;
   int          slvWait = 0;
   int          slaveLat = 0;
   int          accessCount = 0;
   logic        readyOverride = 1'b0;
   logic [31:0] slvMem [0:8191];

   logic [31:0] modelMem [logic [31:0]];
   logic [31:0] modelRdata = '0;
   int          expAccess = 0;
   sbItem_t     sbQ [$];

   int checkCount = 0;
   int passCount = 0;
   int reqCycles = 0;
   logic prevDone = 1'b0;

   bus_master_if #(
      .TIMEOUT   (TIMEOUT_TB),
      .IDLE_ADDR (32'h0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_busy  (cpu_busy),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .address   (address),
      .data      (data),
      .request   (request),
      .r_w       (r_w),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   assign ready = slvReady | readyOverride;

   // The bench parks the data lines at zero whenever the master should not
   // be driving, so a master that fails to release them shows up as a
   // non-zero (or conflicting) value.
   assign data = (request && r_w) ? 32'hzzzz_zzzz :
                 ((slvReady && request && !r_w) ? slvRdata : 32'h0);

   function automatic logic isMapped(input logic [31:0] a);
      return a < 32'h0000_2000;
   endfunction

   // Memory slave: answers a mapped request after slaveLat extra cycles
   // with a single ready pulse.
   always @(posedge clk) begin
      if (!rst_n) begin
         slvReady <= 1'b0;
         slvWait  <= 0;
      end else if (request && !slvReady && isMapped(address)) begin
         if (slvWait >= slaveLat) begin
            slvReady    <= 1'b1;
            slvWait     <= 0;
            accessCount <= accessCount + 1;
            if (r_w) begin
               slvMem[address[12:0]] <= data;
            end else begin
               slvRdata <= slvMem[address[12:0]];
            end
         end else begin
            slvWait <= slvWait + 1;
         end
      end else begin
         slvReady <= 1'b0;
         if (!request) begin
            slvWait <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   // Reference model: mapped addresses behave as plain memory answered after
   // lat+1 cycles, anything else is never answered and aborts after TIMEOUT.
   task automatic pushExpect(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
      sbItem_t it;
      it.we    = we;
      it.addr  = addr;
      it.wdata = wdata;
      if (isMapped(addr)) begin
         it.expErr = 1'b0;
         it.expReq = lat + 2;
         expAccess++;
         if (we) begin
            modelMem[addr] = wdata;
         end else begin
            modelRdata = modelMem.exists(addr) ? modelMem[addr] : 32'h0;
         end
      end else begin
         it.expErr = 1'b1;
         it.expReq = TIMEOUT_TB;
      end
      it.expRdata = modelRdata;
      sbQ.push_back(it);
   endtask

   // Monitor: tracks request length and write data, and scores every
   // completion pulse against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         reqCycles = 0;
         prevDone  = 1'b0;
      end else begin
         if (request) begin
            reqCycles++;
            checkOutput("cmdPending", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
               checkOutput("busAddress", address, sbQ[0].addr);
               checkOutput("busDir", 32'(r_w), 32'(sbQ[0].we));
               if (r_w) begin
                  checkOutput("writeData", data, sbQ[0].wdata);
               end
            end
         end
         if (cpu_done) begin
            checkOutput("doneSingle", 32'(prevDone), 32'd0);
            checkOutput("doneHasCmd", 32'(sbQ.size() != 0), 32'd1);
            if (sbQ.size() != 0) begin
               sbItem_t it;
               it = sbQ.pop_front();
               checkOutput("cpuErr", 32'(cpu_err), 32'(it.expErr));
               checkOutput("cpuRdata", cpu_rdata, it.expRdata);
               checkOutput("reqCycles", 32'(reqCycles), 32'(it.expReq));
               checkOutput("requestLowAtDone", 32'(request), 32'd0);
               checkOutput("addressIdle", address, 32'h0);
               checkOutput("busReleased", data, 32'h0);
            end
            reqCycles = 0;
         end
         prevDone = cpu_done;
      end
   end

   task automatic waitDone();
      int n;
      n = 0;
      while (cpu_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checkCount++;
         $display("[TB] FAIL doneTimeout: got no cpu_done, expected one within 100 cycles");
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, input bit strayInDone);
      int n;
      @(negedge clk);
      n = 0;
      while (cpu_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      slaveLat = lat;
      pushExpect(we, addr, wdata, lat);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(negedge clk);
      cpu_req = 1'b0;
      waitDone();
      if (strayInDone) begin
         readyOverride = 1'b1;
         @(negedge clk);
         readyOverride = 1'b0;
         checkOutput("strayDoneBusy", 32'(cpu_busy), 32'd0);
         checkOutput("strayDoneDone", 32'(cpu_done), 32'd0);
      end
      @(negedge clk);
   endtask

   // Global watchdog so the bench can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      for (int i = 0; i < 8192; i++) begin
         slvMem[i] = 32'h0;
      end
      slvMem[5]   = 32'hDEAD_BEEF;
      modelMem[5] = 32'hDEAD_BEEF;

      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      repeat (2) @(negedge clk);
      checkOutput("rstRequest", 32'(request), 32'd0);
      checkOutput("rstRw", 32'(r_w), 32'd0);
      checkOutput("rstAddress", address, 32'h0);
      checkOutput("rstData", data, 32'h0);
      checkOutput("rstBusy", 32'(cpu_busy), 32'd0);
      checkOutput("rstDone", 32'(cpu_done), 32'd0);
      checkOutput("rstErr", 32'(cpu_err), 32'd0);
      checkOutput("rstRdata", cpu_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] fast read of mem[5]");
      applyStimulus(1'b0, 32'h5, 32'h0, 0, 1'b0);

      $display("[TB] write then read 0x10");
      applyStimulus(1'b1, 32'h10, 32'h1234_5678, 0, 1'b0);
      applyStimulus(1'b0, 32'h10, 32'h0, 0, 1'b0);

      $display("[TB] back-to-back reads with cpu_req held");
      begin
         int dones;
         int n;
         int accBefore;
         @(negedge clk);
         accBefore = accessCount;
         slaveLat  = 0;
         for (int i = 0; i < 3; i++) begin
            pushExpect(1'b0, 32'h5, 32'h0, 0);
         end
         cpu_req  = 1'b1;
         cpu_we   = 1'b0;
         cpu_addr = 32'h5;
         dones = 0;
         n = 0;
         while (dones < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (cpu_done) begin
               dones++;
            end
         end
         cpu_req = 1'b0;
         repeat (4) @(negedge clk);
         checkOutput("b2bDones", 32'(dones), 32'd3);
         checkOutput("b2bQueueEmpty", 32'(sbQ.size()), 32'd0);
         checkOutput("b2bAccesses", 32'(accessCount - accBefore), 32'd3);
      end

      $display("[TB] timeout on unmapped address, then recovery");
      applyStimulus(1'b0, 32'h0010_0000, 32'h0, 0, 1'b0);
      applyStimulus(1'b0, 32'h10, 32'h0, 1, 1'b0);

      $display("[TB] reset in the middle of a transfer");
      @(negedge clk);
      slaveLat = 10;
      pushExpect(1'b0, 32'h20, 32'h0, 10);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h20;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstRequest", 32'(request), 32'd0);
      checkOutput("midRstAddress", address, 32'h0);
      checkOutput("midRstData", data, 32'h0);
      checkOutput("midRstBusy", 32'(cpu_busy), 32'd0);
      checkOutput("midRstDone", 32'(cpu_done), 32'd0);
      checkOutput("midRstRdata", cpu_rdata, 32'h0);
      // The aborted read never completes and reset clears the read register.
      sbQ.delete();
      expAccess--;
      modelRdata = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstDone", 32'(cpu_done), 32'd0);
      applyStimulus(1'b0, 32'h5, 32'h0, 2, 1'b0);

      $display("[TB] stray and undefined ready outside a transfer");
      readyOverride = 1'bx;
      repeat (2) @(negedge clk);
      checkOutput("idleXBusy", 32'(cpu_busy), 32'd0);
      checkOutput("idleXDone", 32'(cpu_done), 32'd0);
      readyOverride = 1'b1;
      @(negedge clk);
      readyOverride = 1'b0;
      checkOutput("idleStrayBusy", 32'(cpu_busy), 32'd0);
      checkOutput("idleStrayDone", 32'(cpu_done), 32'd0);
      applyStimulus(1'b0, 32'h10, 32'h0, 0, 1'b1);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 24; t++) begin
         logic        we;
         logic [31:0] addr;
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            addr = 32'h0010_0000 | 32'($urandom_range(0, 255));
         end else begin
            addr = 32'($urandom_range(0, 63));
         end
         applyStimulus(we, addr, $urandom, int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (5) @(negedge clk);
      checkOutput("finalQueueEmpty", 32'(sbQ.size()), 32'd0);
      checkOutput("finalAccesses", 32'(accessCount), 32'(expAccess));
      checkOutput("finalIdle", 32'(cpu_busy), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
